// File: rtl/ysyx_22050598_wbu.sv
// Write-back unit: 2-entry retire FIFO, load extension, RF write-port arbitration
// against the MDU, and decode bypass. Commit trace outputs need YSYX_22050598_DIFFTEST_EN.
module ysyx_22050598_wbu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic        in_rf_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_ld_funct3,
    input  logic [2:0]  in_ld_off,
    input  logic [63:0] in_alu_res,
    input  logic [63:0] in_ld_raw,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [63:0] mdu_data,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    input  logic [4:0]  fwd_raddr,
    output logic        fwd_hit,
    output logic [63:0] fwd_data,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [63:0] retire_cnt
);
    typedef struct packed {
        logic        wr;    // rf_wen && rd != 0, resolved once at enqueue
        logic [4:0]  rd;
        logic [63:0] data;
    } entry_t;

    entry_t     fifo_q [2];
    logic       head_q, tail_q;
    logic [1:0] count_q, blk_q;
    entry_t     head, new_entry;
    logic       head_valid, starve, head_retire, push;

    function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] raw,
                                             input logic [2:0] off);
        logic [63:0] s;
        s = raw >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{s[7]}}, s[7:0]};
            3'b001:  return {{48{s[15]}}, s[15:0]};
            3'b010:  return {{32{s[31]}}, s[31:0]};
            3'b011:  return s;
            3'b100:  return {56'd0, s[7:0]};
            3'b101:  return {48'd0, s[15:0]};
            3'b110:  return {32'd0, s[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    assign in_ready   = !rst && (count_q != 2'd2);
    assign push       = in_valid && in_ready;
    assign head       = fifo_q[head_q];
    assign head_valid = (count_q != 2'd0);
    assign starve     = (blk_q == 2'd2);
    // A non-writing head never competes for the port; a writing one waits for the MDU unless starved.
    assign head_retire = head_valid && (!head.wr || starve || !mdu_valid);
    assign mdu_ready   = !rst && mdu_valid && !starve;

    always_comb begin
        new_entry.wr   = in_rf_wen && (in_rd != 5'd0);
        new_entry.rd   = in_rd;
        new_entry.data = in_is_load ? load_ext(in_ld_funct3, in_ld_raw, in_ld_off) : in_alu_res;
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 64'd0;
        if (head_retire && head.wr) begin
            rf_wen   = 1'b1;
            rf_waddr = head.rd;
            rf_wdata = head.data;
        end else if (mdu_ready && (mdu_rd != 5'd0)) begin
            rf_wen   = 1'b1;
            rf_waddr = mdu_rd;
            rf_wdata = mdu_data;
        end
    end

    // Older slot first so the younger match overrides it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 64'd0;
        if (fwd_raddr != 5'd0) begin
            if (head_valid && fifo_q[head_q].wr && fifo_q[head_q].rd == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_q[head_q].data;
            end
            if (count_q == 2'd2 && fifo_q[~head_q].wr && fifo_q[~head_q].rd == fwd_raddr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_q[~head_q].data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: validity lives in count_q alone; the two slots are cleared only because it is cheap.
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            blk_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= new_entry;
                tail_q         <= ~tail_q;
            end
            if (head_retire) head_q <= ~head_q;
            count_q <= count_q + {1'b0, push} - {1'b0, head_retire};
            if (head_retire)     blk_q <= 2'd0;
            else if (head_valid) blk_q <= blk_q + 2'd1;
        end
    end

`ifdef YSYX_22050598_DIFFTEST_EN
    logic [63:0] pc_q [2];
    logic [63:0] retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q[0]  <= 64'd0;
            pc_q[1]  <= 64'd0;
            retire_q <= 64'd0;
        end else begin
            if (push)        pc_q[tail_q] <= in_pc;
            if (head_retire) retire_q     <= retire_q + 64'd1;
        end
    end

    assign commit_valid = head_retire;
    assign commit_pc    = head_retire ? pc_q[head_q] : 64'd0;
    assign retire_cnt   = retire_q;
`else
    logic unused_pc;
    assign unused_pc    = ^in_pc;
    assign commit_valid = 1'b0;
    assign commit_pc    = 64'd0;
    assign retire_cnt   = 64'd0;
`endif
endmodule

// File: tb/tb_ysyx_22050598_wbu.sv
// Scoreboard bench for ysyx_22050598_wbu: a queue-based reference model predicts
// each register-file write; a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_ysyx_22050598_wbu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 0, in_ready, in_rf_wen = 0, in_is_load = 0;
    logic [63:0] in_pc = 0, in_alu_res = 0, in_ld_raw = 0;
    logic [4:0]  in_rd = 0, mdu_rd = 0, fwd_raddr = 0, rf_waddr;
    logic [2:0]  in_ld_funct3 = 0, in_ld_off = 0;
    logic        mdu_valid = 0, mdu_ready, rf_wen, fwd_hit, commit_valid;
    logic [63:0] mdu_data = 0, rf_wdata, fwd_data, commit_pc, retire_cnt;

    always #5 clk = ~clk;

    ysyx_22050598_wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_rf_wen(in_rf_wen), .in_is_load(in_is_load),
        .in_ld_funct3(in_ld_funct3), .in_ld_off(in_ld_off), .in_alu_res(in_alu_res),
        .in_ld_raw(in_ld_raw), .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd), .mdu_data(mdu_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .retire_cnt(retire_cnt)
    );

    typedef struct { logic [63:0] pc; logic [4:0] rd; logic wen; logic [63:0] data; } pend_t;
    typedef struct { logic [4:0] addr; logic [63:0] data; } wr_t;

    pend_t       pend_q[$];
    wr_t         exp_q[$];
    int          blocked = 0;
    logic [63:0] retired = 0;
    logic [63:0] pc_ctr = 64'h8000_0000;
    int          n_tests = 0, n_fail = 0;

    logic        o_wen, o_mrdy, o_irdy, o_hit;
    logic [4:0]  o_addr;
    logic [63:0] o_data, o_fdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] raw,
                                             input logic [2:0] off);
        logic [63:0] s;
        s = raw >> (8 * int'(off));
        case (f3)
            3'd0:    return longint'(byte'(s[7:0]));
            3'd1:    return longint'(shortint'(s[15:0]));
            3'd2:    return longint'(int'(s[31:0]));
            3'd3:    return s;
            3'd4:    return s & 64'hFF;
            3'd5:    return s & 64'hFFFF;
            3'd6:    return s & 64'hFFFF_FFFF;
            default: return 64'd0;
        endcase
    endfunction

    // One cycle, entered and left on a negedge: drive, predict, check, advance the model.
    task automatic step(input logic iv, input logic [4:0] rd, input logic wen, input logic ld,
                        input logic [2:0] f3, input logic [2:0] off, input logic [63:0] alu,
                        input logic [63:0] raw, input logic mv, input logic [4:0] mrd,
                        input logic [63:0] md, input logic [4:0] fa,
                        output logic ow, output logic [4:0] oa, output logic [63:0] od,
                        output logic omr, output logic oir, output logic oh,
                        output logic [63:0] ofd);
        bit has_head, needs, ret, macc, acc, hit;
        logic [63:0] fd;
        pend_t e;
        in_valid = iv; in_rd = rd; in_rf_wen = wen; in_is_load = ld; in_ld_funct3 = f3;
        in_ld_off = off; in_alu_res = alu; in_ld_raw = raw; in_pc = pc_ctr;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md; fwd_raddr = fa;
        #1;
        has_head = pend_q.size() > 0;
        needs    = has_head && pend_q[0].wen && pend_q[0].rd != 5'd0;
        acc      = iv && pend_q.size() < 2;
        if (!has_head)         begin ret = 0; macc = mv; end
        else if (!needs)       begin ret = 1; macc = mv; end
        else if (blocked == 2) begin ret = 1; macc = 0;  end
        else if (mv)           begin ret = 0; macc = 1;  end
        else                   begin ret = 1; macc = 0;  end
        hit = 0; fd = 0;
        foreach (pend_q[i])
            if (fa != 0 && pend_q[i].wen && pend_q[i].rd == fa) begin hit = 1; fd = pend_q[i].data; end
        if (ret && needs)           exp_q.push_back('{pend_q[0].rd, pend_q[0].data});
        else if (macc && mrd != 0)  exp_q.push_back('{mrd, md});
        check("in_ready", in_ready, 64'(pend_q.size() < 2));
        check("mdu_ready", mdu_ready, 64'(macc));
        check("fwd_hit", fwd_hit, 64'(hit));
        check("fwd_data", fwd_data, fd);
`ifdef YSYX_22050598_DIFFTEST_EN
        check("commit_valid", commit_valid, 64'(ret));
        if (ret) check("commit_pc", commit_pc, pend_q[0].pc);
        check("retire_cnt", retire_cnt, retired);
`else
        check("commit_valid", commit_valid, 0);
        check("retire_cnt", retire_cnt, 0);
`endif
        ow = rf_wen; oa = rf_waddr; od = rf_wdata; omr = mdu_ready; oir = in_ready;
        oh = fwd_hit; ofd = fwd_data;
        @(posedge clk);
        if (ret) begin
            void'(pend_q.pop_front());
            blocked = 0;
            retired++;
        end else if (has_head) blocked++;
        if (acc) begin
            e.pc = pc_ctr; e.rd = rd; e.wen = wen;
            e.data = ld ? ref_load(f3, raw, off) : alu;
            pend_q.push_back(e);
            pc_ctr += 4;
        end
        @(negedge clk);
    endtask

    task automatic push_alu(input logic [4:0] rd, input logic wen, input logic [63:0] alu,
                            input logic mv, input logic [4:0] mrd, input logic [4:0] fa);
        step(1, rd, wen, 0, 3'd0, 3'd0, alu, 64'd0, mv, mrd, 64'hD00D_0000 + 64'(mrd), fa,
             o_wen, o_addr, o_data, o_mrdy, o_irdy, o_hit, o_fdata);
    endtask

    task automatic idle(input logic mv, input logic [4:0] mrd, input logic [4:0] fa);
        step(0, 5'd0, 0, 0, 3'd0, 3'd0, 64'd0, 64'd0, mv, mrd, 64'hD00D_0000 + 64'(mrd), fa,
             o_wen, o_addr, o_data, o_mrdy, o_irdy, o_hit, o_fdata);
    endtask

    // Monitor: every DUT write must match the oldest prediction, and every prediction must appear.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            if (rf_wen) begin
                if (exp_q.size() == 0) check("unexpected_rf_wen", rf_wen, 0);
                else begin
                    w = exp_q.pop_front();
                    check("rf_waddr", rf_waddr, 64'(w.addr));
                    check("rf_wdata", rf_wdata, w.data);
                end
            end else begin
                check("idle_waddr", rf_waddr, 0);
                check("idle_wdata", rf_wdata, 0);
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    check("missing_rf_wen", rf_wen, 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        mdu_valid = 1; mdu_rd = 5'd9; fwd_raddr = 5'd9;
        #3;
        check("rst_rf_wen", rf_wen, 0);
        check("rst_mdu_ready", mdu_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // LB, off 3
        step(1, 5'd5, 1, 1, 3'b000, 3'd3, 64'd0, 64'h0000_0000_8000_0000, 0, 5'd0, 64'd0, 5'd0,
             o_wen, o_addr, o_data, o_mrdy, o_irdy, o_hit, o_fdata);
        check("in_ready_after_rst", o_irdy, 1);
        idle(0, 5'd0, 5'd0);
        check("lb_wen", o_wen, 1);
        check("lb_waddr", o_addr, 5);
        check("lb_wdata", o_data, 64'hFFFF_FFFF_FFFF_FF80);

        // LWU, off 4
        step(1, 5'd6, 1, 1, 3'b110, 3'd4, 64'd0, 64'h89AB_CDEF_0123_4567, 0, 5'd0, 64'd0, 5'd0,
             o_wen, o_addr, o_data, o_mrdy, o_irdy, o_hit, o_fdata);
        idle(0, 5'd0, 5'd0);
        check("lwu_wdata", o_data, 64'h0000_0000_89AB_CDEF);

        // Starvation under continuous MDU traffic
        push_alu(5'd1, 1, 64'h1111, 1, 5'd9, 5'd0);
        check("st0_mdu_ready", o_mrdy, 1);
        push_alu(5'd2, 1, 64'h2222, 1, 5'd9, 5'd0);
        check("st1_mdu_ready", o_mrdy, 1);
        check("st1_waddr", o_addr, 9);
        push_alu(5'd3, 1, 64'h3333, 1, 5'd9, 5'd0);
        check("st2_in_ready", o_irdy, 0);
        check("st2_mdu_ready", o_mrdy, 1);
        push_alu(5'd3, 1, 64'h3333, 1, 5'd9, 5'd0);
        check("st3_mdu_ready", o_mrdy, 0);
        check("st3_waddr", o_addr, 1);
        check("st3_wdata", o_data, 64'h1111);
        idle(1, 5'd9, 5'd0);
        check("st4_mdu_ready", o_mrdy, 1);
        check("st4_waddr", o_addr, 9);
        idle(0, 5'd0, 5'd0);
        idle(0, 5'd0, 5'd0);

        // rd=0 entry retires alongside an MDU write
        push_alu(5'd0, 1, 64'hDEAD, 1, 5'd9, 5'd0);
        idle(1, 5'd10, 5'd0);
        check("rd0_waddr", o_addr, 10);
`ifdef YSYX_22050598_DIFFTEST_EN
        check("rd0_retire_cnt", retire_cnt, 5);
`else
        check("rd0_retire_cnt", retire_cnt, 0);
`endif

        // Bypass of the youngest pending write
        push_alu(5'd7, 1, 64'h11, 1, 5'd9, 5'd0);
        push_alu(5'd7, 1, 64'h22, 1, 5'd9, 5'd0);
        idle(1, 5'd9, 5'd7);
        check("byp_hit", o_hit, 1);
        check("byp_data", o_fdata, 64'h22);
        idle(1, 5'd9, 5'd0);
        check("byp_x0_hit", o_hit, 0);
        idle(0, 5'd0, 5'd0);
        idle(0, 5'd0, 5'd0);

        // Asynchronous reset with two entries pending
        push_alu(5'd12, 1, 64'hC, 1, 5'd9, 5'd0);
        push_alu(5'd13, 1, 64'hD, 1, 5'd9, 5'd0);
        in_valid = 0; fwd_raddr = 5'd12;
        rst = 1;
        #1;
        check("arst_rf_wen", rf_wen, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_mdu_ready", mdu_ready, 0);
        check("arst_fwd_hit", fwd_hit, 0);
        check("arst_retire_cnt", retire_cnt, 0);
        check("arst_pending_pred", 64'(exp_q.size()), 0);
        pend_q.delete(); blocked = 0; retired = 0;
        @(posedge clk); #1;
        check("arst_no_write", rf_wen, 0);
        @(negedge clk);
        rst = 0;
        idle(0, 5'd0, 5'd12);
        check("post_rst_in_ready", o_irdy, 1);
        check("post_rst_wen", o_wen, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 8,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), {$urandom(), $urandom()}, 5'($urandom_range(0, 3)),
                 o_wen, o_addr, o_data, o_mrdy, o_irdy, o_hit, o_fdata);
        end
        for (int i = 0; i < 4; i++) idle(0, 5'd0, 5'd0);
        #3;
        check("final_pending_pred", 64'(exp_q.size()), 0);
        check("final_fifo_drained", 64'(pend_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
